// File: rtl/neo_fade_player_if.sv
// ROM read bus between the fade player and its colour ROM.
// The player drives the address; the ROM answers one clock later.
interface neo_fade_player_if;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/neo_fade_player.sv
// Walks the colour ROM and streams GRB pixels onto a WS2812 line.
// Optional macro NEO_FADE_PLAYER_DIM_EN adds the bright dimming port.
module neo_fade_player #(
  parameter int NUM_LEDS    = 8,
  parameter int ADDR_STRIDE = 4,
  parameter int HOLD_FRAMES = 4,
  parameter int T_BIT       = 20,
  parameter int T0H         = 6,
  parameter int T1H         = 11,
  parameter int T_LATCH     = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
`ifdef NEO_FADE_PLAYER_DIM_EN
  input  logic [1:0]       bright,
`endif
  neo_fade_player_if.master rom,
  output logic             neo_out,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       base_addr
);

  localparam int CMAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SEND, LATCH
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    led_idx_q, led_idx_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [7:0]    base_q, base_d;
  logic [7:0]    rd_addr_q, rd_addr_d;
  logic [23:0]   pix_q, pix_d;
  logic          neo_q, neo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW-1:0] th;
  logic [CW-1:0] cnt_nx;
  logic [7:0]    g_x, r_x, b_x;
  logic          unused_msb;

  function automatic logic [7:0] expand(input logic [4:0] x);
    return {x, x[4:2]};
  endfunction

  assign unused_msb = rom.rd_data[15];

  always_comb begin
    g_x = expand(rom.rd_data[14:10]);
    r_x = expand(rom.rd_data[9:5]);
    b_x = expand(rom.rd_data[4:0]);
`ifdef NEO_FADE_PLAYER_DIM_EN
    g_x = g_x >> bright;
    r_x = r_x >> bright;
    b_x = b_x >> bright;
`endif
  end

  assign th     = pix_q[bit_idx_q] ? CW'(T1H) : CW'(T0H);
  assign cnt_nx = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    led_idx_d   = led_idx_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    base_d      = base_q;
    rd_addr_d   = rd_addr_q;
    pix_d       = pix_q;
    neo_d       = neo_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        neo_d = 1'b0;
        if (enable) begin
          state_d   = FETCH;
          led_idx_d = '0;
          rd_addr_d = base_q;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        pix_d     = {g_x, r_x, b_x};
        bit_idx_d = 5'd23;
        cnt_d     = '0;
        neo_d     = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (cnt_q == CW'(T_BIT - 1)) begin
          cnt_d = '0;
          if (bit_idx_q == 5'd0) begin
            neo_d = 1'b0;
            if (led_idx_q < 8'(NUM_LEDS - 1)) begin
              led_idx_d = led_idx_q + 8'd1;
              rd_addr_d = rd_addr_q + 8'(ADDR_STRIDE);
              state_d   = FETCH;
            end else begin
              state_d = LATCH;
              done_d  = (T_LATCH == 1);
            end
          end else begin
            bit_idx_d = bit_idx_q - 5'd1;
            neo_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_nx;
          neo_d = (cnt_nx < th);
        end
      end
      LATCH: begin
        neo_d = 1'b0;
        if (cnt_q == CW'(T_LATCH - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (frame_cnt_q == 8'(HOLD_FRAMES - 1)) begin
            frame_cnt_d = '0;
            base_d      = base_q + 8'd1;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end else begin
          cnt_d  = cnt_nx;
          done_d = (cnt_nx == CW'(T_LATCH - 1));
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      led_idx_q   <= '0;
      bit_idx_q   <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      base_q      <= '0;
      rd_addr_q   <= '0;
      pix_q       <= '0;
      neo_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      led_idx_q   <= led_idx_d;
      bit_idx_q   <= bit_idx_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      base_q      <= base_d;
      rd_addr_q   <= rd_addr_d;
      pix_q       <= pix_d;
      neo_q       <= neo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom.rd_addr = rd_addr_q;
  assign neo_out     = neo_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign base_addr   = base_q;

endmodule

// File: tb/tb_neo_fade_player.sv
// Bench for neo_fade_player: waveform model plus a fast-timing
// second instance that walks base_addr through its 8-bit wrap.
module tb_neo_fade_player;

  localparam int NL = 8, ST = 4, HF = 4;
  localparam int TB = 20, T0 = 6, T1 = 11, TL = 1000;
  localparam int NL2 = 2, ST2 = 200, HF2 = 1;
  localparam int TB2 = 3, T02 = 1, T12 = 2, TL2 = 2;

  typedef bit wave_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst2_n, enable, enable2;
  logic neo_out, busy, frame_done;
  logic neo2, busy2, done2;
  logic [7:0] base_addr, base2;
  logic [15:0] rom [256];
`ifdef NEO_FADE_PLAYER_DIM_EN
  logic [1:0] bright;
  logic [1:0] bright2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int frames  = 0;

  neo_fade_player_if bus ();
  neo_fade_player_if bus2 ();

  always_ff @(posedge clk) bus.rd_data  <= rom[bus.rd_addr];
  always_ff @(posedge clk) bus2.rd_data <= rom[bus2.rd_addr];

  neo_fade_player #(
    .NUM_LEDS(NL), .ADDR_STRIDE(ST), .HOLD_FRAMES(HF),
    .T_BIT(TB), .T0H(T0), .T1H(T1), .T_LATCH(TL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef NEO_FADE_PLAYER_DIM_EN
    .bright(bright),
`endif
    .rom(bus.master), .neo_out(neo_out), .busy(busy),
    .frame_done(frame_done), .base_addr(base_addr)
  );

  neo_fade_player #(
    .NUM_LEDS(NL2), .ADDR_STRIDE(ST2), .HOLD_FRAMES(HF2),
    .T_BIT(TB2), .T0H(T02), .T1H(T12), .T_LATCH(TL2)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .enable(enable2),
`ifdef NEO_FADE_PLAYER_DIM_EN
    .bright(bright2),
`endif
    .rom(bus2.master), .neo_out(neo2), .busy(busy2),
    .frame_done(done2), .base_addr(base2)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 5-bit channel scaled up to 8 bits by replicating its top bits
  function automatic int expand(int x);
    return x * 8 + x / 4;
  endfunction

  function automatic wave_t build_wave(int base, int br);
    wave_t w;
    int a, word, pix, hi;
    for (int i = 0; i < NL; i++) begin
      a    = (base + i * ST) % 256;
      word = int'(rom[a]);
      pix  = (expand((word >> 10) & 31) >> br) * 65536
           + (expand((word >> 5) & 31) >> br) * 256
           + (expand(word & 31) >> br);
      w.push_back(1'b0);
      w.push_back(1'b0);
      for (int k = 23; k >= 0; k--) begin
        hi = ((pix >> k) & 1) != 0 ? T1 : T0;
        for (int c = 0; c < TB; c++) w.push_back(c < hi);
      end
    end
    for (int c = 0; c < TL; c++) w.push_back(1'b0);
    return w;
  endfunction

  task automatic fill_rom(int mode);
    for (int a = 0; a < 256; a++) begin
      case (mode)
        0: rom[a] = 16'h7FFF;
        1: rom[a] = 16'h0000;
        2: rom[a] = 16'(a);
        default: rom[a] = 16'($urandom);
      endcase
    end
  endtask

  task automatic run_frame(string tag, int abort_at);
    wave_t exp_w;
    wave_t got;
    int guard, br, fd_n, fd_pos, diffs;
    br = 0;
`ifdef NEO_FADE_PLAYER_DIM_EN
    br = int'($urandom_range(0, 3));
    bright = 2'(br);
`endif
    exp_w = build_wave((frames / HF) % 256, br);
    @(negedge clk);
    enable = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!busy && guard < 5);
    enable = 1'b0;
    check({tag, " start"}, busy, 1);
    if (!busy) return;
    fd_n = 0;
    fd_pos = -1;
    while (busy && got.size() < exp_w.size() + 10) begin
      if (abort_at >= 0 && got.size() == abort_at) begin
        check({tag, " pre-rst neo"}, neo_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check({tag, " rst neo"}, neo_out, 0);
        check({tag, " rst busy"}, busy, 0);
        check({tag, " rst addr"}, bus.rd_addr, 0);
        check({tag, " rst base"}, base_addr, 0);
        frames = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check({tag, " post-rst idle"}, busy, 0);
        return;
      end
      got.push_back(neo_out);
      if (frame_done) begin
        fd_n++;
        fd_pos = got.size() - 1;
      end
      @(negedge clk);
    end
    frames++;
    diffs = 0;
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      if (got[i] != exp_w[i]) diffs++;
    check({tag, " len"}, got.size(), exp_w.size());
    check({tag, " len+idle"}, got.size() + 1, NL * (2 + 24 * TB) + TL + 1);
    check({tag, " wave diffs"}, diffs, 0);
    check({tag, " done count"}, fd_n, 1);
    check({tag, " done pos"}, fd_pos, exp_w.size() - 1);
    check({tag, " base"}, base_addr, (frames / HF) % 256);
    repeat (3) @(negedge clk);
    check({tag, " stops"}, busy, 0);
  endtask

  task automatic main_seq();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 10 == 0) begin
        check("rst neo", neo_out, 0);
        check("rst busy", busy, 0);
        check("rst addr", bus.rd_addr, 0);
        check("rst base", base_addr, 0);
        check("rst done", frame_done, 0);
      end
    end
    fill_rom(0);
    run_frame("ones", -1);
    fill_rom(1);
    run_frame("zeros", -1);
    fill_rom(2);
    run_frame("addr1", -1);
    run_frame("addr2", -1);
    for (int f = 0; f < 4; f++) begin
      fill_rom(3);
      run_frame("rand", -1);
    end
    fill_rom(0);
    run_frame("abort", 2 + 11 * TB + 3);
    fill_rom(3);
    run_frame("fresh", -1);
  endtask

  // Fast instance: one frame per base step, so 256 frames cover the wrap
  task automatic wrap_seq();
    int q[$];
    int last, guard;
    for (int f = 0; f <= 256; f++) begin
      check("d2 base", base2, (f / HF2) % 256);
      @(negedge clk);
      enable2 = 1'b1;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!busy2 && guard < 5);
      enable2 = 1'b0;
      q.delete();
      last = -1;
      guard = 0;
      while (busy2 && guard < 400) begin
        if (int'(bus2.rd_addr) != last) begin
          last = int'(bus2.rd_addr);
          q.push_back(last);
        end
        @(negedge clk);
        guard++;
      end
      check("d2 ended", busy2, 0);
      check("d2 naddr", q.size(), NL2);
      if (q.size() == NL2) begin
        check("d2 addr0", q[0], ((f / HF2) % 256));
        check("d2 addr1", q[1], ((f / HF2) % 256 + ST2) % 256);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rst2_n  = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;
`ifdef NEO_FADE_PLAYER_DIM_EN
    bright  = 2'd0;
    bright2 = 2'd0;
`endif
    fill_rom(1);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    fork
      main_seq();
      wrap_seq();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
